vga_rect_fill: RTL and testbench
================================

Name: vga_rect_fill

Overview:
- Pixel-stream generator that fills an axis-aligned rectangle with one colour on the DESim 160x120, 3-bit "VGA" framebuffer.
- Sits directly upstream of the simulator VGA port: drives VGA_X, VGA_Y, VGA_COLOR and plot, one pixel per CLOCK_50 cycle.
- Driven by user logic (SW/KEY decode) through a start/busy/done handshake.

Parameters:
- XRES, 160, visible columns; pixels with x >= XRES are clipped.
- YRES, 120, visible rows; pixels with y >= YRES are clipped.
- XW, 8, column coordinate width.
- YW, 7, row coordinate width.
- CW, 3, colour width.

Ports:
- CLOCK_50  in  1  system clock; all logic on the rising edge.
- resetn  in  1  synchronous, active-low reset.
- start  in  1  request pulse; sampled only when busy=0.
- x0  in  XW  rectangle left column.
- y0  in  YW  rectangle top row.
- width  in  XW  columns to fill (0..255).
- height  in  YW  rows to fill (0..127).
- color  in  CW  fill colour.
- VGA_X  out  XW  pixel column.
- VGA_Y  out  YW  pixel row.
- VGA_COLOR  out  CW  pixel colour.
- plot  out  1  high for exactly the cycles carrying a pixel to draw.
- busy  out  1  high while the engine is drawing.
- done  out  1  one-cycle pulse when a fill completes.

Behaviour:
- Reset, resetn=0 at a clock edge: state=IDLE; VGA_X=0, VGA_Y=0, VGA_COLOR=0, plot=0, busy=0, done=0. Aborts any fill in progress with no done pulse.
- FSM states: IDLE, DRAW, DONE.
- IDLE: on start=1, latch x0, y0, width, height, color.
  - width=0 or height=0: go to DONE.
  - Otherwise: go to DRAW, with counters cx=0, cy=0.
- DRAW: busy=1. Each cycle presents pixel (x0+cx, y0+cy).
  - cx increments; at cx=width-1, cx clears and cy increments. Raster order, x inner.
  - After pixel (width-1, height-1): go to DONE.
- DONE: a single cycle with done=1, busy=0, plot=0, then go to IDLE.
  - start=1 in the DONE cycle is accepted, giving back-to-back fills.
- Latency: start sampled at edge N; first pixel is registered on VGA_X/VGA_Y/plot during cycle N+1.
  - Fill time is width*height cycles in DRAW, plus one DONE cycle.
- Arithmetic: x0+cx is computed in XW+1 bits and y0+cy in YW+1 bits; no wrap-around.
  - Pixels with sum >= XRES or >= YRES keep their cycle but have plot=0.
  - VGA_X/VGA_Y carry the low bits of the sum.
- start while busy=1 is ignored; latched inputs do not change mid-fill.
- Outputs are registered. VGA_X, VGA_Y and VGA_COLOR hold their last value when plot=0.

Optional Feature:
- Macro: VGA_RECT_FILL_CLEAR_ON_RESET_EN.
- When defined: leaving reset enters an internal clear pass that fills 0..XRES-1 x 0..YRES-1 with colour 0.
  - The pass takes 19200 cycles; busy=1 throughout, start is ignored, and no done pulse is produced.
  - The engine then enters IDLE.
- When undefined: leaving reset goes directly to IDLE with no clear pass.

Decomposition:
- Package vga_fill_pkg holds the XRES, YRES, XW, YW and CW defaults and the state enum (IDLE, DRAW, DONE, plus CLEAR under the macro).
- One sub-module, rect_scan_counter: a cx/cy raster counter with load, enable and last flag. It is shared by the fill and the clear pass.

Test Plan:
- Reset release; start with x0=10, y0=5, width=3, height=2, color=5.
  - Expect 6 plot cycles at (10,5), (11,5), (12,5), (10,6), (11,6), (12,6), colour 5.
  - First plot one cycle after start; done pulses one cycle after the last plot.
- width=0, height=4.
  - Expect no plot; done one cycle after start edge +1; busy never high.
- Clipping: x0=158, y0=119, width=4, height=3.
  - Expect 12 DRAW cycles with plot only at (158,119) and (159,119).
- start asserted repeatedly during a 4x4 fill.
  - Expect the fill unaffected, exactly 16 cycles, and one done.
  - A start in the DONE cycle immediately begins the next fill.
- resetn=0 mid-fill at pixel 7 of 20.
  - Expect all outputs 0 the next cycle and no done.
  - A new start after reset works normally.
- With VGA_RECT_FILL_CLEAR_ON_RESET_EN: after reset, expect 19200 plot cycles of colour 0 covering every pixel once.
  - start is ignored during the pass; busy falls afterwards.

Source files
------------

// File: rtl/vga_fill_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : vga_fill_pkg                                                 |
// | Description : Shared defaults (framebuffer geometry, widths) and the fill  |
// |               engine state encoding for vga_rect_fill.                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package vga_fill_pkg;

  // DESim framebuffer geometry and field widths
  localparam int DEF_XRES = 160;
  localparam int DEF_YRES = 120;
  localparam int DEF_XW   = 8;
  localparam int DEF_YW   = 7;
  localparam int DEF_CW   = 3;

`ifdef VGA_RECT_FILL_CLEAR_ON_RESET_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAW  = 2'd1,
    DONE  = 2'd2,
    CLEAR = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAW  = 2'd1,
    DONE  = 2'd2
  } state_t;
`endif

endpackage
`default_nettype wire

// File: rtl/rect_scan_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rect_scan_counter                                            |
// | Description : Raster (x inner) cx/cy counter over a width x height area    |
// |               with synchronous load-to-zero, advance enable and a flag     |
// |               marking the final position. The next position is exported   |
// |               so the owner can register pixel outputs without extra lag.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rect_scan_counter
  import vga_fill_pkg::*;
#(
  parameter int XW = DEF_XW,
  parameter int YW = DEF_YW
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          load,
  input  logic          en,
  input  logic [XW-1:0] width,
  input  logic [YW-1:0] height,
  output logic [XW-1:0] cx_nxt,
  output logic [YW-1:0] cy_nxt,
  output logic          last
);

  logic [XW-1:0] cx;
  logic [YW-1:0] cy;
  logic          row_end;

  assign row_end = (cx == width - XW'(1));
  assign last    = row_end && (cy == height - YW'(1));

  // Next raster position: load restarts at the origin, enable steps x then y
  always_comb begin
    cx_nxt = cx;
    cy_nxt = cy;
    if (load) begin
      cx_nxt = '0;
      cy_nxt = '0;
    end else if (en) begin
      if (row_end) begin
        cx_nxt = '0;
        cy_nxt = cy + YW'(1);
      end else begin
        cx_nxt = cx + XW'(1);
      end
    end
  end

  // Position register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cx <= '0;
      cy <= '0;
    end else begin
      cx <= cx_nxt;
      cy <= cy_nxt;
    end
  end

endmodule
`default_nettype wire

// File: rtl/vga_rect_fill.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : vga_rect_fill                                                |
// | Description : Rectangle fill pixel-stream generator for the 160x120 3-bit  |
// |               DESim VGA port. One pixel per clock, start/busy/done         |
// |               handshake, off-screen pixels clipped (plot=0).               |
// |               Optional: VGA_RECT_FILL_CLEAR_ON_RESET_EN adds a full-screen |
// |               colour-0 clear pass after every reset.                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module vga_rect_fill
  import vga_fill_pkg::*;
#(
  parameter int XRES = DEF_XRES,
  parameter int YRES = DEF_YRES,
  parameter int XW   = DEF_XW,
  parameter int YW   = DEF_YW,
  parameter int CW   = DEF_CW
) (
  input  logic          CLOCK_50,
  input  logic          resetn,
  input  logic          start,
  input  logic [XW-1:0] x0,
  input  logic [YW-1:0] y0,
  input  logic [XW-1:0] width,
  input  logic [YW-1:0] height,
  input  logic [CW-1:0] color,
  output logic [XW-1:0] VGA_X,
  output logic [YW-1:0] VGA_Y,
  output logic [CW-1:0] VGA_COLOR,
  output logic          plot,
  output logic          busy,
  output logic          done
);

  localparam logic [XW:0] X_LIMIT = (XW+1)'(XRES);
  localparam logic [YW:0] Y_LIMIT = (YW+1)'(YRES);

  state_t        state, state_nxt;

  // Latched fill request; the *_nxt values feed both the latch and the pixel adders
  logic [XW-1:0] x0_q, x0_nxt;
  logic [YW-1:0] y0_q, y0_nxt;
  logic [XW-1:0] w_q,  w_nxt;
  logic [YW-1:0] h_q,  h_nxt;
  logic [CW-1:0] col_q, col_nxt;

  logic          cnt_load, cnt_en, cnt_last;
  logic [XW-1:0] cx_nxt;
  logic [YW-1:0] cy_nxt;

  logic          emit;
  logic [XW:0]   sum_x;
  logic [YW:0]   sum_y;
  logic          on_screen;

  logic [XW-1:0] vga_x_nxt;
  logic [YW-1:0] vga_y_nxt;
  logic [CW-1:0] vga_c_nxt;
  logic          busy_nxt;

`ifdef VGA_RECT_FILL_CLEAR_ON_RESET_EN
  logic          clr_pend, clr_pend_nxt;
`endif

  rect_scan_counter #(
    .XW (XW),
    .YW (YW)
  ) u_scan (
    .clk    (CLOCK_50),
    .resetn (resetn),
    .load   (cnt_load),
    .en     (cnt_en),
    .width  (w_nxt),
    .height (h_nxt),
    .cx_nxt (cx_nxt),
    .cy_nxt (cy_nxt),
    .last   (cnt_last)
  );

  // Next-state, request latch and counter control
  always_comb begin
    state_nxt = state;
    x0_nxt    = x0_q;
    y0_nxt    = y0_q;
    w_nxt     = w_q;
    h_nxt     = h_q;
    col_nxt   = col_q;
    cnt_load  = 1'b0;
    cnt_en    = 1'b0;
    emit      = 1'b0;
`ifdef VGA_RECT_FILL_CLEAR_ON_RESET_EN
    clr_pend_nxt = clr_pend;
`endif
    case (state)
      // DONE accepts a new request exactly like IDLE for back-to-back fills
      IDLE, DONE: begin
        state_nxt = IDLE;
`ifdef VGA_RECT_FILL_CLEAR_ON_RESET_EN
        if (clr_pend) begin
          clr_pend_nxt = 1'b0;
          x0_nxt       = '0;
          y0_nxt       = '0;
          w_nxt        = XW'(XRES);
          h_nxt        = YW'(YRES);
          col_nxt      = '0;
          cnt_load     = 1'b1;
          emit         = 1'b1;
          state_nxt    = CLEAR;
        end else
`endif
        if (start) begin
          x0_nxt  = x0;
          y0_nxt  = y0;
          w_nxt   = width;
          h_nxt   = height;
          col_nxt = color;
          if ((width == '0) || (height == '0)) begin
            state_nxt = DONE;
          end else begin
            cnt_load  = 1'b1;
            emit      = 1'b1;
            state_nxt = DRAW;
          end
        end
      end
      DRAW: begin
        if (cnt_last) begin
          state_nxt = DONE;
        end else begin
          cnt_en = 1'b1;
          emit   = 1'b1;
        end
      end
`ifdef VGA_RECT_FILL_CLEAR_ON_RESET_EN
      // Clear pass ends silently: no done pulse
      CLEAR: begin
        if (cnt_last) begin
          state_nxt = IDLE;
        end else begin
          cnt_en = 1'b1;
          emit   = 1'b1;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Pixel for the upcoming cycle; sums are one bit wider so they never wrap
  always_comb begin
    sum_x     = {1'b0, x0_nxt} + {1'b0, cx_nxt};
    sum_y     = {1'b0, y0_nxt} + {1'b0, cy_nxt};
    on_screen = emit && (sum_x < X_LIMIT) && (sum_y < Y_LIMIT);
    vga_x_nxt = on_screen ? sum_x[XW-1:0] : VGA_X;
    vga_y_nxt = on_screen ? sum_y[YW-1:0] : VGA_Y;
    vga_c_nxt = on_screen ? col_nxt : VGA_COLOR;
`ifdef VGA_RECT_FILL_CLEAR_ON_RESET_EN
    busy_nxt  = (state_nxt == DRAW) || (state_nxt == CLEAR);
`else
    busy_nxt  = (state_nxt == DRAW);
`endif
  end

  // State, request latch and registered outputs
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state     <= IDLE;
      x0_q      <= '0;
      y0_q      <= '0;
      w_q       <= '0;
      h_q       <= '0;
      col_q     <= '0;
      VGA_X     <= '0;
      VGA_Y     <= '0;
      VGA_COLOR <= '0;
      plot      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef VGA_RECT_FILL_CLEAR_ON_RESET_EN
      clr_pend  <= 1'b1;
`endif
    end else begin
      state     <= state_nxt;
      x0_q      <= x0_nxt;
      y0_q      <= y0_nxt;
      w_q       <= w_nxt;
      h_q       <= h_nxt;
      col_q     <= col_nxt;
      VGA_X     <= vga_x_nxt;
      VGA_Y     <= vga_y_nxt;
      VGA_COLOR <= vga_c_nxt;
      plot      <= on_screen;
      busy      <= busy_nxt;
      done      <= (state_nxt == DONE);
`ifdef VGA_RECT_FILL_CLEAR_ON_RESET_EN
      clr_pend  <= clr_pend_nxt;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_rect_fill.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_vga_rect_fill                                             |
// | Description : Directed self-checking bench for vga_rect_fill. Honours      |
// |               VGA_RECT_FILL_CLEAR_ON_RESET_EN when defined.                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_vga_rect_fill;

  logic       CLOCK_50 = 1'b0;
  logic       resetn   = 1'b0;
  logic       start    = 1'b0;
  logic [7:0] x0       = '0;
  logic [6:0] y0       = '0;
  logic [7:0] width    = '0;
  logic [6:0] height   = '0;
  logic [2:0] color    = '0;
  logic [7:0] VGA_X;
  logic [6:0] VGA_Y;
  logic [2:0] VGA_COLOR;
  logic       plot, busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  vga_rect_fill dut (
    .CLOCK_50  (CLOCK_50),
    .resetn    (resetn),
    .start     (start),
    .x0        (x0),
    .y0        (y0),
    .width     (width),
    .height    (height),
    .color     (color),
    .VGA_X     (VGA_X),
    .VGA_Y     (VGA_Y),
    .VGA_COLOR (VGA_COLOR),
    .plot      (plot),
    .busy      (busy),
    .done      (done)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Advance one clock and settle past the edge
  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic set_rect(input logic [7:0] x, input logic [6:0] y,
                          input logic [7:0] w, input logic [6:0] h,
                          input logic [2:0] c);
    x0 = x; y0 = y; width = w; height = h; color = c;
  endtask

`ifdef VGA_RECT_FILL_CLEAR_ON_RESET_EN
  // Full-screen clear after reset release: every pixel once, colour 0, start ignored
  task automatic test_clear();
    bit cov [0:19199];
    int plots = 0, dups = 0, bad = 0, dones = 0, busy_cyc = 0;
    bit ended = 0;
    for (int k = 0; k < 19200; k++) cov[k] = 1'b0;
    set_rect(8'd0, 7'd0, 8'd1, 7'd1, 3'd5);
    start = 1'b1;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      step();
      if (!busy) begin
        ended = 1;
        break;
      end
      busy_cyc++;
      if (done) dones++;
      if (plot) begin
        plots++;
        if (VGA_X >= 8'd160 || VGA_Y >= 7'd120 || VGA_COLOR != 3'd0) bad++;
        else begin
          if (cov[int'(VGA_Y) * 160 + int'(VGA_X)]) dups++;
          cov[int'(VGA_Y) * 160 + int'(VGA_X)] = 1'b1;
        end
      end
    end
    start = 1'b0;
    n_checks++;
    if (!ended) begin n_fail++; $display("FAIL clear_end: busy still %0b, required 0", busy); end
    n_checks++;
    if (plots != 19200) begin n_fail++; $display("FAIL clear_plots: got %0d, required 19200", plots); end
    n_checks++;
    if (busy_cyc != 19200) begin n_fail++; $display("FAIL clear_busy: got %0d, required 19200", busy_cyc); end
    n_checks++;
    if (dups != 0 || bad != 0) begin n_fail++; $display("FAIL clear_cover: dups %0d bad %0d, required 0 0", dups, bad); end
    n_checks++;
    if (dones != 0 || done !== 1'b0) begin n_fail++; $display("FAIL clear_done: got %0d pulses, required 0", dones); end
  endtask
`endif

  task automatic test_reset();
    resetn = 1'b0;
    start  = 1'b1;
    set_rect(8'd1, 7'd1, 8'd1, 7'd1, 3'd7);
    step(); step();
    n_checks++;
    if ({VGA_X, VGA_Y, VGA_COLOR, plot, busy, done} !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, required 0", {VGA_X, VGA_Y, VGA_COLOR, plot, busy, done});
    end
    start  = 1'b0;
    resetn = 1'b1;
`ifdef VGA_RECT_FILL_CLEAR_ON_RESET_EN
    test_clear();
`else
    step();
    n_checks++;
    if ({plot, busy, done} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_idle: plot/busy/done %b, required 000", {plot, busy, done});
    end
`endif
  endtask

  task automatic test_basic();
    set_rect(8'd10, 7'd5, 8'd3, 7'd2, 3'd5);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if ({plot, VGA_X, VGA_Y, VGA_COLOR, busy, done} !==
          {1'b1, 8'(10 + i % 3), 7'(5 + i / 3), 3'd5, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL basic_px%0d: plot %b x %0d y %0d c %0d busy %b done %b, required 1 %0d %0d 5 1 0",
                 i, plot, VGA_X, VGA_Y, VGA_COLOR, busy, done, 10 + i % 3, 5 + i / 3);
      end
      step();
    end
    n_checks++;
    if ({plot, busy, done} !== 3'b001) begin
      n_fail++; $display("FAIL basic_done: plot/busy/done %b, required 001", {plot, busy, done});
    end
    step();
    n_checks++;
    if ({plot, busy, done} !== 3'b000) begin
      n_fail++; $display("FAIL basic_idle: plot/busy/done %b, required 000", {plot, busy, done});
    end
  endtask

  task automatic test_zero();
    set_rect(8'd40, 7'd40, 8'd0, 7'd4, 3'd2);
    start = 1'b1;
    step();
    start = 1'b0;
    n_checks++;
    if ({plot, busy, done} !== 3'b001) begin
      n_fail++; $display("FAIL zero_done: plot/busy/done %b, required 001", {plot, busy, done});
    end
    step();
    n_checks++;
    if ({plot, busy, done} !== 3'b000) begin
      n_fail++; $display("FAIL zero_idle: plot/busy/done %b, required 000", {plot, busy, done});
    end
  endtask

  task automatic test_clip();
    set_rect(8'd158, 7'd119, 8'd4, 7'd3, 3'd4);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      n_checks++;
      if (i < 2) begin
        if ({plot, VGA_X, VGA_Y, VGA_COLOR, busy, done} !==
            {1'b1, 8'(158 + i), 7'd119, 3'd4, 1'b1, 1'b0}) begin
          n_fail++;
          $display("FAIL clip_px%0d: plot %b x %0d y %0d c %0d busy %b, required 1 %0d 119 4 1",
                   i, plot, VGA_X, VGA_Y, VGA_COLOR, busy, 158 + i);
        end
      end else begin
        if ({plot, VGA_X, busy, done} !== {1'b0, 8'd159, 1'b1, 1'b0}) begin
          n_fail++;
          $display("FAIL clip_hold%0d: plot %b x %0d busy %b done %b, required 0 159 1 0",
                   i, plot, VGA_X, busy, done);
        end
      end
      step();
    end
    n_checks++;
    if ({plot, busy, done} !== 3'b001) begin
      n_fail++; $display("FAIL clip_done: plot/busy/done %b, required 001", {plot, busy, done});
    end
    step();
  endtask

  task automatic test_back_to_back();
    int dones = 0;
    set_rect(8'd20, 7'd30, 8'd4, 7'd4, 3'd3);
    start = 1'b1;
    step();
    // Change the request and keep start high; the running fill must not notice
    set_rect(8'd50, 7'd60, 8'd2, 7'd1, 3'd6);
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if ({plot, VGA_X, VGA_Y, VGA_COLOR, busy} !==
          {1'b1, 8'(20 + i % 4), 7'(30 + i / 4), 3'd3, 1'b1}) begin
        n_fail++;
        $display("FAIL b2b_px%0d: plot %b x %0d y %0d c %0d busy %b, required 1 %0d %0d 3 1",
                 i, plot, VGA_X, VGA_Y, VGA_COLOR, busy, 20 + i % 4, 30 + i / 4);
      end
      if (done) dones++;
      step();
    end
    n_checks++;
    if ({plot, busy, done} !== 3'b001 || dones != 0) begin
      n_fail++;
      $display("FAIL b2b_done: plot/busy/done %b early dones %0d, required 001 0", {plot, busy, done}, dones);
    end
    step();
    n_checks++;
    if ({plot, VGA_X, VGA_Y, VGA_COLOR, busy, done} !== {1'b1, 8'd50, 7'd60, 3'd6, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL b2b_next0: plot %b x %0d y %0d c %0d, required 1 50 60 6", plot, VGA_X, VGA_Y, VGA_COLOR);
    end
    start = 1'b0;
    step();
    n_checks++;
    if ({plot, VGA_X, VGA_Y, VGA_COLOR} !== {1'b1, 8'd51, 7'd60, 3'd6}) begin
      n_fail++;
      $display("FAIL b2b_next1: plot %b x %0d y %0d c %0d, required 1 51 60 6", plot, VGA_X, VGA_Y, VGA_COLOR);
    end
    step();
    n_checks++;
    if ({plot, busy, done} !== 3'b001) begin
      n_fail++; $display("FAIL b2b_done2: plot/busy/done %b, required 001", {plot, busy, done});
    end
    step();
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    set_rect(8'd0, 7'd0, 8'd5, 7'd4, 3'd7);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 6; i++) step();
    n_checks++;
    if ({plot, VGA_X, VGA_Y, VGA_COLOR} !== {1'b1, 8'd1, 7'd1, 3'd7}) begin
      n_fail++;
      $display("FAIL mid_px6: plot %b x %0d y %0d c %0d, required 1 1 1 7", plot, VGA_X, VGA_Y, VGA_COLOR);
    end
    resetn = 1'b0;
    step();
    n_checks++;
    if ({VGA_X, VGA_Y, VGA_COLOR, plot, busy, done} !== 21'd0) begin
      n_fail++;
      $display("FAIL mid_reset: got %h, required 0", {VGA_X, VGA_Y, VGA_COLOR, plot, busy, done});
    end
    resetn = 1'b1;
`ifdef VGA_RECT_FILL_CLEAR_ON_RESET_EN
    begin
      bit ended = 0;
      for (int cyc = 0; cyc < 20000; cyc++) begin
        step();
        if (done) dones++;
        if (!busy) begin ended = 1; break; end
      end
      n_checks++;
      if (!ended) begin n_fail++; $display("FAIL mid_clear_end: busy %b, required 0", busy); end
    end
`endif
    for (int i = 0; i < 4; i++) begin
      step();
      if (done) dones++;
    end
    n_checks++;
    if (dones != 0 || {plot, busy} !== 2'b00) begin
      n_fail++; $display("FAIL mid_no_done: dones %0d plot/busy %b, required 0 00", dones, {plot, busy});
    end
    set_rect(8'd1, 7'd2, 8'd1, 7'd1, 3'd2);
    start = 1'b1;
    step();
    start = 1'b0;
    n_checks++;
    if ({plot, VGA_X, VGA_Y, VGA_COLOR, busy, done} !== {1'b1, 8'd1, 7'd2, 3'd2, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL mid_restart: plot %b x %0d y %0d c %0d busy %b, required 1 1 2 2 1",
               plot, VGA_X, VGA_Y, VGA_COLOR, busy);
    end
    step();
    n_checks++;
    if ({plot, busy, done} !== 3'b001) begin
      n_fail++; $display("FAIL mid_restart_done: plot/busy/done %b, required 001", {plot, busy, done});
    end
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_clip();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
